i2c_target: RTL

Byte-oriented I2C target (slave) that bridges the host's two-wire bus to the internal 8-bit register bank. Decodes START/STOP/repeated START, matches the 7-bit device address, and turns bus transfers into single-cycle register write/read strobes with an auto-incrementing register pointer. Sits between the board-level SCL/SDA pads (open-drain) and the configuration register bank, running entirely in the system clock domain.

---
 rtl/i2c_target.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target bridging SCL/SDA pads to an 8-bit register bank.
// Runs fully in the clk domain, with an auto-incrementing register pointer.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEV_ADDR = 4'd1;
  localparam logic [3:0] S_ACK_DEV  = 4'd2;
  localparam logic [3:0] S_REG_ADDR = 4'd3;
  localparam logic [3:0] S_ACK_REG  = 4'd4;
  localparam logic [3:0] S_WR_DATA  = 4'd5;
  localparam logic [3:0] S_ACK_WR   = 4'd6;
  localparam logic [3:0] S_RD_DATA  = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;

  logic       scl_s1_q, scl_s2_q, scl_s3_q;
  logic       sda_s1_q, sda_s2_q, sda_s3_q;
  logic [3:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       ack_q, ack_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       fetch_p1_q, fetch_p2_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // s3 holds the previous synchronized level for edge detection
  assign scl_rise  = scl_s2_q & ~scl_s3_q;
  assign scl_fall  = ~scl_s2_q & scl_s3_q;
  assign start_det = scl_s2_q & scl_s3_q & ~sda_s2_q & sda_s3_q;
  assign stop_det  = scl_s2_q & scl_s3_q & sda_s2_q & ~sda_s3_q;
  assign rx_byte   = {rx_q[6:0], sda_s2_q};

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    ack_d     = ack_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;

    // Fetched byte lands two clk after the read strobe; pointer moves one clk later
    if (fetch_p1_q) tx_d = reg_rdata;
    if (wr_en_q || fetch_p2_q) ptr_d = ptr_q + 8'd1;

    if (start_det) begin
      state_d   = S_DEV_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ack_d    = 1'b0;
    end else begin
      case (state_q)
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            rx_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == S_DEV_ADDR) begin
                if (rx_byte[7:1] == DEVICE_ADDR) begin
                  state_d = S_ACK_DEV;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == S_REG_ADDR) begin
                ptr_d   = rx_byte;
                state_d = S_ACK_REG;
              end else begin
                wr_en_d = 1'b1;
                wdata_d = rx_byte;
                state_d = S_ACK_WR;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        S_ACK_DEV, S_ACK_REG, S_ACK_WR: begin
          if (scl_rise && ack_q && state_q == S_ACK_DEV && rw_q) rd_en_d = 1'b1;
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              ack_d     = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == S_ACK_DEV && rw_q) begin
                state_d  = S_RD_DATA;
                sda_oe_d = ~tx_q[7];
              end else begin
                state_d  = (state_q == S_ACK_DEV) ? S_REG_ADDR : S_WR_DATA;
                sda_oe_d = 1'b0;
              end
            end
          end
        end

        // tx_q[7] is always the bit currently on the bus
        S_RD_DATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              rd_en_d = 1'b1;
              ack_d   = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
          if (scl_fall && ack_q) begin
            ack_d     = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_RD_DATA;
            sda_oe_d  = ~tx_q[7];
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_s3_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_s3_q   <= 1'b1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= 8'h00;
      wdata_q    <= 8'h00;
      ack_q      <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      fetch_p1_q <= 1'b0;
      fetch_p2_q <= 1'b0;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_s3_q   <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_s3_q   <= sda_s2_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      fetch_p1_q <= rd_en_q;
      fetch_p2_q <= fetch_p1_q;
    end
  end

endmodule
